demux64_6_wr: RTL and testbench
===============================

DEMUX64_6_WR -- requirements
Module: demux64_6_wr

Interface
REQ-001 SHALL have parameter RESET_VAL, default 1'b0, value loaded into every storage bit on reset.
REQ-002 SHALL have parameter BANK_W, default 16, bits per bank; fixed at 16 for this release.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write request for one bit.
REQ-006 SHALL have port wr_idx  input  6  bit index 0..63; bits [5:4] select bank, bits [3:0] select bit in bank.
REQ-007 SHALL have port wr_data  input  1  value written to the selected bit.
REQ-008 SHALL have port flush_req  input  1  request to clear the whole array.
REQ-009 SHALL have port busy  output  1  high while a flush is in progress; writes are not accepted.
REQ-010 SHALL have port flush_done  output  1  one-cycle pulse at flush completion.
REQ-011 SHALL have port wr_drop  output  1  one-cycle pulse, registered, when wr_en was asserted while busy.
REQ-012 SHALL have ports bank0..bank3  output  16 each  registered storage; bankN[b] = bit (N*16+b), feeding the 64:1 read mux.

Function
REQ-013 SHALL, when wr_en=1 and busy=0, set storage bit wr_idx to wr_data on the rising edge; the new value is visible on bankN the next cycle (1-cycle latency); no other bit changes.
REQ-014 SHALL implement FSM states IDLE, FLUSH, DONE.
REQ-015 SHALL go IDLE->FLUSH on flush_req=1, clearing the 2-bit bank counter to 0.
REQ-016 SHALL, in FLUSH, write all 16 bits of bank[counter] to 0 each cycle and increment the counter; after bank 3 is cleared (4 cycles), go FLUSH->DONE.
REQ-017 SHALL, in DONE, assert flush_done for exactly one cycle, then go DONE->IDLE.
REQ-018 SHALL drive busy=1 in FLUSH and DONE, and 0 in IDLE.
REQ-019 SHALL, on wr_en=1 while busy=1, leave storage unchanged and pulse wr_drop the following cycle.
REQ-020 SHALL, on wr_en=1 and flush_req=1 in the same IDLE cycle, perform the write that cycle and begin the flush next cycle, so the written bit is cleared by the flush.
REQ-021 SHALL ignore flush_req while busy=1; no queuing.
REQ-022 SHALL take bank-counter wrap 3->0 only on the FLUSH->DONE transition; the counter is don't-care outside FLUSH.

Reset
REQ-023 SHALL, with rst=1 at a rising edge, load RESET_VAL into all 64 bits and force state=IDLE, busy=0, flush_done=0, wr_drop=0.
REQ-024 SHALL give rst priority over wr_en and flush_req; a reset mid-flush aborts the flush and suppresses flush_done.

Configuration
REQ-025 SHALL, with DEMUX64_FLUSH_EN defined, include the flush FSM, bank counter, busy, flush_done and wr_drop as specified.
REQ-026 SHALL, without DEMUX64_FLUSH_EN, ignore flush_req, tie busy=0, flush_done=0 and wr_drop=0, omit the FSM, and accept every write.

Structure
REQ-027 SHALL take state encoding typedef (IDLE, FLUSH, DONE), IDX_W=6, BANK_W=16 and NUM_BANKS=4 from shared package demux_pkg.
REQ-028 SHALL instantiate one sub-module dec6_64, a combinational 6-to-64 one-hot decoder gated by write enable, producing the per-bit write strobes.

Verification
REQ-029 SHALL cover: reset with RESET_VAL=1 -> all bankN=16'hFFFF, busy=0.
REQ-030 SHALL cover: write idx=37, data=1 after reset-to-0 -> next cycle bank2=16'h0020, other banks 0.
REQ-031 SHALL cover: all 64 bits written to 1, then flush_req -> busy high 5 cycles; bank0 reads 0 after cycle 1 and bank3 after cycle 4; flush_done pulses in cycle 5; all banks 0.
REQ-032 SHALL cover: write idx=5 issued at flush cycle 2 -> wr_drop pulse next cycle; bank0 stays 0 after flush.
REQ-033 SHALL cover: same-cycle write idx=63 data=1 plus flush_req -> bank3=16'h8000 for one cycle, then cleared by the flush.
REQ-034 SHALL cover: rst asserted at flush cycle 2 -> flush_done never pulses; state IDLE; banks=RESET_VAL.

Source files
------------

// File: rtl/demux64_6_wr_pkg.sv
// demux_pkg: shared widths and flush FSM state encoding for demux64_6_wr
package demux_pkg;
    localparam int IDX_W     = 6;
    localparam int BANK_W    = 16;
    localparam int NUM_BANKS = 4;
    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;
endpackage

// File: rtl/demux64_6_wr_if.sv
// demux64_6_wr_if: write/flush request bus and bank read-out of the 64-bit array
interface demux64_6_wr_if;
    import demux_pkg::*;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_data;
    logic                 flush_req;
    logic                 busy;
    logic                 flush_done;
    logic                 wr_drop;
    logic [BANK_W-1:0]    bank0;
    logic [BANK_W-1:0]    bank1;
    logic [BANK_W-1:0]    bank2;
    logic [BANK_W-1:0]    bank3;
    modport master (
        output wr_en, wr_idx, wr_data, flush_req,
        input  busy, flush_done, wr_drop, bank0, bank1, bank2, bank3
    );
    modport slave (
        input  wr_en, wr_idx, wr_data, flush_req,
        output busy, flush_done, wr_drop, bank0, bank1, bank2, bank3
    );
endinterface

// File: rtl/demux64_6_wr_dec6_64.sv
// dec6_64: combinational 6-to-64 one-hot write-strobe decoder gated by enable
module dec6_64
    import demux_pkg::*;
(
    input  logic                  i_en,
    input  logic [IDX_W-1:0]      i_idx,
    output logic [(1<<IDX_W)-1:0] o_strobe
);
    assign o_strobe = i_en ? ((1<<IDX_W)'(1) << i_idx) : '0;
endmodule

// File: rtl/demux64_6_wr.sv
// demux64_6_wr: 64-bit bit-addressable array in four 16-bit banks; bank-serial flush FSM when DEMUX64_FLUSH_EN is defined
module demux64_6_wr
    import demux_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0,
    parameter int   BANK_W    = 16
) (
    input logic           clk,
    input logic           rst,
    demux64_6_wr_if.slave bus
);
    localparam int NBITS = NUM_BANKS * BANK_W;
    logic [NBITS-1:0] r_mem;
    logic [NBITS-1:0] w_strobe;
    logic [NBITS-1:0] w_clr;
    logic             w_busy;

    dec6_64 u_dec (
        .i_en    (bus.wr_en & ~w_busy),
        .i_idx   (bus.wr_idx),
        .o_strobe(w_strobe)
    );

`ifdef DEMUX64_FLUSH_EN
    state_t     r_state;
    logic [1:0] r_cnt;
    logic       r_drop;

    // flush sequencer: one bank cleared per FLUSH cycle, counter wraps 3->0 on entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= (r_state == IDLE)  ? (bus.flush_req ? FLUSH : IDLE) :
                       (r_state == FLUSH) ? ((r_cnt == 2'd3) ? DONE : FLUSH) : IDLE;
            r_cnt   <= (r_state == FLUSH) ? r_cnt + 2'd1 : 2'd0;
            r_drop  <= bus.wr_en & w_busy;
        end
    end

    assign w_busy         = (r_state != IDLE);
    assign w_clr          = (r_state == FLUSH) ? ({{(NBITS-BANK_W){1'b0}}, {BANK_W{1'b1}}} << (r_cnt * BANK_W)) : '0;
    assign bus.busy       = w_busy;
    assign bus.flush_done = (r_state == DONE);
    assign bus.wr_drop    = r_drop;
`else
    logic w_unused_flush;
    assign w_unused_flush = bus.flush_req;
    assign w_busy         = 1'b0;
    assign w_clr          = '0;
    assign bus.busy       = 1'b0;
    assign bus.flush_done = 1'b0;
    assign bus.wr_drop    = 1'b0;
`endif

    // storage: accepted write updates one bit; a flushing bank is forced to zero
    always_ff @(posedge clk) begin
        if (rst) r_mem <= {NBITS{RESET_VAL}};
        else     r_mem <= ((r_mem & ~w_strobe) | (w_strobe & {NBITS{bus.wr_data}})) & ~w_clr;
    end

    assign bus.bank0 = r_mem[0*BANK_W +: BANK_W];
    assign bus.bank1 = r_mem[1*BANK_W +: BANK_W];
    assign bus.bank2 = r_mem[2*BANK_W +: BANK_W];
    assign bus.bank3 = r_mem[3*BANK_W +: BANK_W];
endmodule

// File: tb/tb_demux64_6_wr.sv
// tb_demux64_6_wr: randomized + directed bench against a behavioural array/flush model
module tb_demux64_6_wr;
`ifdef DEMUX64_FLUSH_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux64_6_wr_if bus ();
    demux64_6_wr_if bus1 ();
    demux64_6_wr u_dut (.clk(clk), .rst(rst), .bus(bus));
    demux64_6_wr #(.RESET_VAL(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic [63:0] m_mem;
    int m_phase;
    logic m_drop;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model: phase 0 idle, 1..4 clearing bank phase-1, 5 done pulse
    always @(posedge clk) begin
        if (rst) begin
            m_mem   <= '0;
            m_phase <= 0;
            m_drop  <= 1'b0;
        end else begin
            m_drop <= FE && bus.wr_en && m_phase != 0;
            if (bus.wr_en && m_phase == 0) m_mem[bus.wr_idx] <= bus.wr_data;
            if (m_phase >= 1 && m_phase <= 4) m_mem[(m_phase-1)*16 +: 16] <= 16'h0;
            m_phase <= (m_phase == 0) ? ((FE && bus.flush_req) ? 1 : 0) : (m_phase == 5 ? 0 : m_phase + 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", bus.busy, 64'(m_phase != 0));
            check("flush_done", bus.flush_done, 64'(m_phase == 5));
            check("wr_drop", bus.wr_drop, 64'(m_drop));
            check("bank0", bus.bank0, 64'(m_mem[15:0]));
            check("bank1", bus.bank1, 64'(m_mem[31:16]));
            check("bank2", bus.bank2, 64'(m_mem[47:32]));
            check("bank3", bus.bank3, 64'(m_mem[63:48]));
        end
    end

    initial begin
        bus.wr_en = 0; bus.wr_idx = 0; bus.wr_data = 0; bus.flush_req = 0;
        bus1.wr_en = 0; bus1.wr_idx = 0; bus1.wr_data = 0; bus1.flush_req = 0;
        tick(); tick();
        rst = 0;
        chk_en = 1;
        check("rv1_bank0", bus1.bank0, 64'hFFFF);
        check("rv1_bank1", bus1.bank1, 64'hFFFF);
        check("rv1_bank2", bus1.bank2, 64'hFFFF);
        check("rv1_bank3", bus1.bank3, 64'hFFFF);
        check("rv1_busy", bus1.busy, 64'h0);
        check("rst_bank2", bus.bank2, 64'h0);
        bus.wr_en = 1; bus.wr_idx = 6'd37; bus.wr_data = 1;
        tick();
        bus.wr_en = 0;
        check("w37_bank2", bus.bank2, 64'h0020);
        check("w37_bank0", bus.bank0, 64'h0);
        check("w37_bank3", bus.bank3, 64'h0);
        for (int i = 0; i < 64; i++) begin
            bus.wr_en = 1; bus.wr_idx = 6'(i); bus.wr_data = 1;
            tick();
        end
        bus.wr_en = 0; bus.flush_req = 1;
        tick();
        bus.flush_req = 0;
        check("fl_c1_busy", bus.busy, 64'(FE));
        check("fl_c1_bank0", bus.bank0, 64'hFFFF);
        tick();
        check("fl_c2_bank0", bus.bank0, FE ? 64'h0 : 64'hFFFF);
        check("fl_c2_bank1", bus.bank1, 64'hFFFF);
        tick(); tick(); tick();
        check("fl_c5_bank3", bus.bank3, FE ? 64'h0 : 64'hFFFF);
        check("fl_c5_done", bus.flush_done, 64'(FE));
        check("fl_c5_busy", bus.busy, 64'(FE));
        tick();
        check("fl_end_busy", bus.busy, 64'h0);
        check("fl_end_done", bus.flush_done, 64'h0);
        bus.flush_req = 1;
        tick();
        bus.flush_req = 0;
        tick();
        bus.wr_en = 1; bus.wr_idx = 6'd5; bus.wr_data = 1;
        tick();
        bus.wr_en = 0;
        check("drop_pulse", bus.wr_drop, 64'(FE));
        tick(); tick(); tick();
        check("drop_bank0", bus.bank0, FE ? 64'h0 : 64'hFFFF);
        bus.wr_en = 1; bus.wr_idx = 6'd63; bus.wr_data = 1; bus.flush_req = 1;
        tick();
        bus.wr_en = 0; bus.flush_req = 0;
        check("w63fl_bank3", bus.bank3, FE ? 64'h8000 : 64'hFFFF);
        repeat (5) tick();
        check("w63fl_clr", bus.bank3, FE ? 64'h0 : 64'hFFFF);
        bus.flush_req = 1;
        tick();
        bus.flush_req = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("abort_busy", bus.busy, 64'h0);
        check("abort_done", bus.flush_done, 64'h0);
        check("abort_bank1", bus.bank1, 64'h0);
        repeat (6) tick();
        for (int i = 0; i < 600; i++) begin
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.wr_idx    = 6'($urandom_range(0, 63));
            bus.wr_data   = 1'($urandom_range(0, 1));
            bus.flush_req = ($urandom_range(0, 11) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            tick();
        end
        bus.wr_en = 0; bus.flush_req = 0; rst = 0;
        repeat (7) tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
